fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 123 ++++++++++++
 tb/tb_fetch_unit.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word reads to instruction memory, buffers
// one returned instruction for decode, and handles branch redirects,
// including redirects that arrive while a read is still outstanding.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        instr_ready,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [6:0]  opcode,
    output logic        misaligned_err
);

    typedef enum logic [1:0] {FETCH, VALID, DRAIN, ERROR} state_t;

    state_t      state;
    logic [31:0] pc;
    logic        req;
    logic [31:0] addr;
    logic        ackd;
    logic        misaligned;

    // An ack only counts while a request is actually outstanding.
    assign ackd       = req & imem_ack;
    assign misaligned = redirect_valid & (redirect_pc[1:0] != 2'b00);

    assign imem_req  = req;
    assign imem_addr = addr;
    assign opcode    = instr[6:0];

    // Fetch sequencing: request issue, buffer load, redirect and error handling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= FETCH;
            pc             <= RESET_PC;
            req            <= 1'b0;
            addr           <= RESET_PC;
            instr          <= 32'h0;
            instr_pc       <= 32'h0;
            instr_valid    <= 1'b0;
            misaligned_err <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (misaligned) begin
                        // A pending read keeps its request up until it is acked.
                        state          <= ERROR;
                        misaligned_err <= 1'b1;
                        instr_valid    <= 1'b0;
                        if (ackd) req <= 1'b0;
                    end else if (redirect_valid) begin
                        pc <= redirect_pc;
                        if (!req || ackd) begin
                            // No read left in flight: go straight to the target.
                            req  <= 1'b1;
                            addr <= redirect_pc;
                        end else begin
                            // Stale read still in flight: wait for it, then discard.
                            state <= DRAIN;
                        end
                    end else if (!req) begin
                        req  <= 1'b1;
                        addr <= pc;
                    end else if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_pc    <= pc;
                        pc          <= pc + 32'd4;
                        req         <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= VALID;
                    end
                end
                VALID: begin
                    if (misaligned) begin
                        state          <= ERROR;
                        misaligned_err <= 1'b1;
                        instr_valid    <= 1'b0;
                    end else if (redirect_valid) begin
                        instr_valid <= 1'b0;
                        pc          <= redirect_pc;
                        req         <= 1'b1;
                        addr        <= redirect_pc;
                        state       <= FETCH;
                    end else if (instr_ready) begin
                        instr_valid <= 1'b0;
                        req         <= 1'b1;
                        addr        <= pc;
                        state       <= FETCH;
                    end
                end
                DRAIN: begin
                    if (misaligned) begin
                        state          <= ERROR;
                        misaligned_err <= 1'b1;
                        if (ackd) req <= 1'b0;
                    end else begin
                        if (redirect_valid) pc <= redirect_pc;
                        if (imem_ack) begin
                            // Stale data is dropped; the most recent target wins.
                            req   <= 1'b1;
                            addr  <= redirect_valid ? redirect_pc : pc;
                            state <= FETCH;
                        end
                    end
                end
                ERROR: begin
                    if (ackd) req <= 1'b0;
                end
                default: state <= ERROR;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_ready;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  opcode;
    logic        misaligned_err;

    int tests = 0;
    int fails = 0;

    // Reference model: one optional outstanding read plus a one-entry buffer.
    logic        m_req, m_stale, m_bv, m_err;
    logic [31:0] m_pc, m_addr, m_instr, m_ipc;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_ready(instr_ready), .instr_valid(instr_valid),
        .instr(instr), .instr_pc(instr_pc), .opcode(opcode),
        .misaligned_err(misaligned_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        imem_ack = 1'b0; imem_rdata = 32'h0; redirect_valid = 1'b0;
        redirect_pc = 32'h0; instr_ready = 1'b0;
    endtask

    // Leaves rst_n released just after an edge; the next edge issues RESET_PC.
    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic model_reset();
        m_req = 1'b0; m_stale = 1'b0; m_bv = 1'b0; m_err = 1'b0;
        m_pc = 32'h0; m_addr = 32'h0; m_instr = 32'h0; m_ipc = 32'h0;
    endtask

    task automatic model_issue(input logic [31:0] a);
        m_req = 1'b1; m_addr = a; m_stale = 1'b0;
    endtask

    task automatic model_step(input logic ack, input logic [31:0] rdata,
                              input logic rv, input logic [31:0] rpc, input logic rdy);
        logic done;
        done = m_req && ack;
        if (m_err) begin
            if (done) m_req = 1'b0;
        end else if (rv && rpc[1:0] != 2'b00) begin
            m_err = 1'b1; m_bv = 1'b0;
            if (done) m_req = 1'b0;
        end else if (m_bv) begin
            if (rv) begin
                m_bv = 1'b0; m_pc = rpc; model_issue(rpc);
            end else if (rdy) begin
                m_bv = 1'b0; model_issue(m_pc);
            end
        end else if (rv) begin
            m_pc = rpc;
            if (done || !m_req) model_issue(rpc);
            else m_stale = 1'b1;
        end else if (!m_req) begin
            model_issue(m_pc);
        end else if (done) begin
            if (m_stale) model_issue(m_pc);
            else begin
                m_bv = 1'b1; m_instr = rdata; m_ipc = m_addr;
                m_pc = m_addr + 32'd4; m_req = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        #2;
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", imem_req); end
        tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
        tests++; if ({instr_valid, misaligned_err} !== 2'b00) begin fails++; $display("FAIL reset_flags: got %b want 00", {instr_valid, misaligned_err}); end
        tests++; if ({instr, instr_pc} !== 64'h0) begin fails++; $display("FAIL reset_buf: got %h/%h want 0/0", instr, instr_pc); end
        tick();
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_held_req: got %b want 0", imem_req); end
        rst_n = 1'b1;
        tick();
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin fails++; $display("FAIL first_req: got %b/%h want 1/00000000", imem_req, imem_addr); end
    endtask

    task automatic test_sequential();
        do_reset();
        tick();
        imem_ack = 1'b1; imem_rdata = 32'h0000_0033; instr_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) begin
                tests++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'(4 * (k / 2))) begin
                    fails++; $display("FAIL seq_req%0d: got v=%b req=%b addr=%h want v=0 req=1 addr=%h", k, instr_valid, imem_req, imem_addr, 4 * (k / 2)); end
            end else begin
                tests++; if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr_pc !== 32'(4 * (k / 2)) || opcode !== 7'h33) begin
                    fails++; $display("FAIL seq_instr%0d: got v=%b req=%b pc=%h op=%h want v=1 req=0 pc=%h op=33", k, instr_valid, imem_req, instr_pc, opcode, 4 * (k / 2)); end
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_backpressure();
        logic [31:0] r;
        r = $urandom;
        do_reset();
        tick();
        imem_ack = 1'b1; imem_rdata = r;
        tick();
        for (int k = 0; k < 5; k++) begin
            imem_rdata = $urandom;
            tests++; if (instr_valid !== 1'b1 || instr !== r || instr_pc !== 32'h0 || opcode !== r[6:0] || imem_req !== 1'b0) begin
                fails++; $display("FAIL bp_hold%0d: got v=%b instr=%h pc=%h op=%h req=%b want v=1 instr=%h pc=0 req=0", k, instr_valid, instr, instr_pc, opcode, imem_req, r); end
            tick();
        end
        imem_ack = 1'b0; instr_ready = 1'b1;
        tick();
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h4 || instr_valid !== 1'b0) begin
            fails++; $display("FAIL bp_release: got req=%b addr=%h v=%b want req=1 addr=4 v=0", imem_req, imem_addr, instr_valid); end
        clear_inputs();
    endtask

    task automatic test_drain();
        do_reset();
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
                fails++; $display("FAIL drain_stale%0d: got req=%b addr=%h v=%b want req=1 addr=0 v=0", k, imem_req, imem_addr, instr_valid); end
            tick();
        end
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        tests++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            fails++; $display("FAIL drain_redir: got v=%b req=%b addr=%h want v=0 req=1 addr=100", instr_valid, imem_req, imem_addr); end
        imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
        tick();
        tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== 32'h13) begin
            fails++; $display("FAIL drain_target: got v=%b pc=%h instr=%h want v=1 pc=100 instr=13", instr_valid, instr_pc, instr); end
        clear_inputs();
    endtask

    task automatic test_simultaneous();
        do_reset();
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h40; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        tick();
        clear_inputs();
        tests++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            fails++; $display("FAIL simul: got v=%b req=%b addr=%h want v=0 req=1 addr=40", instr_valid, imem_req, imem_addr); end
        imem_ack = 1'b1; imem_rdata = 32'h0000_0073;
        tick();
        tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || opcode !== 7'h73) begin
            fails++; $display("FAIL simul_target: got v=%b pc=%h op=%h want v=1 pc=40 op=73", instr_valid, instr_pc, opcode); end
        clear_inputs();
    endtask

    task automatic test_wrap();
        do_reset();
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0; imem_ack = 1'b1;
        tick();
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
            fails++; $display("FAIL wrap_top: got req=%b addr=%h want req=1 addr=fffffffc", imem_req, imem_addr); end
        imem_rdata = 32'h0000_0033;
        tick();
        imem_ack = 1'b0; instr_ready = 1'b1;
        tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC) begin
            fails++; $display("FAIL wrap_instr: got v=%b pc=%h want v=1 pc=fffffffc", instr_valid, instr_pc); end
        tick();
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            fails++; $display("FAIL wrap_next: got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr); end
        clear_inputs();
    endtask

    task automatic test_error();
        do_reset();
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        tick();
        redirect_valid = 1'b0; instr_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tests++; if (misaligned_err !== 1'b1 || instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
                fails++; $display("FAIL err_pending%0d: got err=%b v=%b req=%b addr=%h want err=1 v=0 req=1 addr=0", k, misaligned_err, instr_valid, imem_req, imem_addr); end
            tick();
        end
        imem_ack = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            tests++; if (misaligned_err !== 1'b1 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin
                fails++; $display("FAIL err_sticky%0d: got err=%b v=%b req=%b want err=1 v=0 req=0", k, misaligned_err, instr_valid, imem_req); end
            imem_ack = 1'($urandom); imem_rdata = $urandom; instr_ready = 1'($urandom);
            redirect_valid = 1'($urandom); redirect_pc = $urandom & 32'hFFFF_FFFC;
            tick();
        end
        do_reset();
        tests++; if (misaligned_err !== 1'b0) begin fails++; $display("FAIL err_cleared: got %b want 0", misaligned_err); end
        tick();
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0201;
        tick();
        clear_inputs();
        tests++; if (misaligned_err !== 1'b1 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin
            fails++; $display("FAIL err_from_valid: got err=%b v=%b req=%b want err=1 v=0 req=0", misaligned_err, instr_valid, imem_req); end
    endtask

    task automatic test_async_reset();
        do_reset();
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        tests++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_valid !== 1'b0 || misaligned_err !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin
            fails++; $display("FAIL async_reset: got req=%b addr=%h v=%b err=%b instr=%h pc=%h want all zero", imem_req, imem_addr, instr_valid, misaligned_err, instr, instr_pc); end
        imem_ack = 1'b1; imem_rdata = 32'h0000_0BAD;
        tick();
        rst_n = 1'b1; imem_ack = 1'b0;
        tick();
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0 || instr !== 32'h0) begin
            fails++; $display("FAIL async_post: got req=%b addr=%h v=%b instr=%h want req=1 addr=0 v=0 instr=0", imem_req, imem_addr, instr_valid, instr); end
        clear_inputs();
    endtask

    task automatic test_random();
        logic a, rv, rdy;
        logic [31:0] d, rpc;
        for (int seg = 0; seg < 8; seg++) begin
            do_reset();
            model_reset();
            for (int c = 0; c < 60; c++) begin
                tests++; if (imem_req !== m_req || imem_addr !== m_addr || instr_valid !== m_bv || misaligned_err !== m_err) begin
                    fails++; $display("FAIL rand_ctrl s%0d c%0d: got req=%b addr=%h v=%b err=%b want req=%b addr=%h v=%b err=%b",
                        seg, c, imem_req, imem_addr, instr_valid, misaligned_err, m_req, m_addr, m_bv, m_err); end
                if (m_bv) begin
                    tests++; if (instr !== m_instr || instr_pc !== m_ipc || opcode !== m_instr[6:0]) begin
                        fails++; $display("FAIL rand_buf s%0d c%0d: got instr=%h pc=%h op=%h want instr=%h pc=%h", seg, c, instr, instr_pc, opcode, m_instr, m_ipc); end
                end
                a = ($urandom_range(0, 2) != 0);
                d = $urandom;
                rdy = ($urandom_range(0, 2) != 0);
                rv = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
                else rpc = $urandom & 32'hFFFF_FFFC;
                if ($urandom_range(0, 99) < seg) rpc[1:0] = 2'($urandom_range(1, 3));
                imem_ack = a; imem_rdata = d; instr_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
                model_step(a, d, rv, rpc, rdy);
                tick();
            end
        end
        clear_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        test_reset();
        test_sequential();
        test_backpressure();
        test_drain();
        test_simultaneous();
        test_wrap();
        test_error();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
